exe_stage_mc: RTL
=================

Name: exe_stage_mc

Overview:
- Parametrised execute stage with a multi-cycle multiply path and a registered valid/ready output.
- Computes the ALU result and the branch target, and owns the NZCV status register.
- Single-cycle ops complete in 1 cycle. MUL takes XLEN+1 cycles; upstream stalls via in_ready.
- Sits between the ID/EX pipeline register and the EX/MEM register. Replaces the fixed 32-bit single-cycle execute stage.

Parameters:
- XLEN, 32, datapath width (>=8).
- IMM_W, 24, branch offset field width (< XLEN-2).
- MUL_EN, 1, 0 = multiply path removed; a MUL request executes as MOV.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  stage can accept an operation this cycle
- exe_cmd  in  4  ALU command
- mul  in  1  operation is a multiply (exe_cmd ignored)
- s  in  1  update status flags on completion
- mem_r_en  in  1  load address calculation
- mem_w_en  in  1  store address calculation
- pc  in  XLEN  pc+4 of the operation
- val1  in  XLEN  first operand
- val2  in  XLEN  second operand (already shifted/immediate)
- signed_imm  in  IMM_W  branch offset
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream accepts the result
- alu_res  out  XLEN  result
- branch_addr  out  XLEN  pc + (sext(signed_imm) << 2), mod 2^XLEN
- n, z, c, v  out  1 each  status register

Behaviour:
- Accept = in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready).
- exe_cmd encoding:
  - 0001 MOV = val2
  - 1001 MVN = ~val2
  - 0010 ADD
  - 0011 ADC = val1+val2+c
  - 0100 SUB = val1-val2
  - 0101 SBC = val1-val2-!c
  - 0110 AND
  - 0111 ORR
  - 1000 EOR
  - other codes: result 0, flags unaffected.
- mem_r_en | mem_w_en forces ADD and suppresses the flag update.
- Arithmetic is XLEN+1 bits wide.
  - C = carry out for ADD/ADC; C = NOT borrow for SUB/SBC.
  - V = signed overflow.
  - Logical/MOV ops leave C and V unchanged.
  - N = res[XLEN-1]; Z = (res == 0).
- FSM states: IDLE, MUL.
  - IDLE, accept with single-cycle op: alu_res, branch_addr and flags (if s) load at that edge; out_valid = 1 next cycle. Latency 1.
  - IDLE, accept with mul (MUL_EN=1): latch operands, clear accumulator, counter = 0, go to MUL.
  - MUL: radix-2 shift-add, one bit per cycle. After XLEN iterations, load the low XLEN product bits into alu_res; update N and Z only if s (C, V kept); return to IDLE. Total latency XLEN+1 cycles from accept to out_valid.
- Output register: out_valid is held with alu_res/branch_addr stable until out_ready. out_valid & out_ready with no new completion → out_valid = 0. A new completion in the same cycle as the drain overwrites the register and keeps out_valid = 1 (back-to-back single-cycle throughput of 1/cycle).
- Flags update at the same edge the result is loaded, never at drain. ADC/SBC use the c value current at accept (the flags of the previous completed op, including a MUL).
- Reset (asynchronous, any state, including mid-MUL): state = IDLE; out_valid = 0; alu_res = 0; branch_addr = 0; n = z = c = v = 0; counter = 0. The in-progress multiply is discarded.
- in_valid while in MUL: ignored; in_ready = 0.

Test Plan:
- XLEN=32, c=0: ADD 0x7FFFFFFF+1 with s=1 → alu_res 0x80000000, N=1 Z=0 C=0 V=1, out_valid 1 cycle after accept.
- SUB 5-5 (s=1), then ADC 0xFFFFFFFF+0 → first: Z=1 C=1; second: result 0x00000000, C=1, Z=1.
- mem_r_en=1, val1 0x100, val2 0x8, s=1, prior flags NZCV=1010 → alu_res 0x108, flags stay 1010.
- MUL 0xFFFF x 0x10001, s=1 → in_ready low 33 cycles, alu_res 0xFFFFFFFF, N=1, C/V unchanged. Same op with rst pulsed low at cycle 10 → out_valid never asserts, flags 0000.
- out_ready held 0 for 3 cycles after an ADD → alu_res stable, in_ready=0. Then 4 back-to-back MOVs with out_ready=1 → 4 results in 4 consecutive cycles.
- pc 0x1000, signed_imm 0xFFFFFE → branch_addr 0x00000FF8; signed_imm 0x000003 → 0x0000100C.

Source files
------------

// File: rtl/exe_stage_mc.sv
// Execute stage: single-cycle ALU plus an optional radix-2 shift-add multiplier.
// Owns the NZCV status register and a valid/ready output register that holds
// alu_res/branch_addr until the downstream stage takes them.
module exe_stage_mc #(
    parameter int XLEN   = 32,
    parameter int IMM_W  = 24,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       exe_cmd,
    input  logic             mul,
    input  logic             s,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  val1,
    input  logic [XLEN-1:0]  val2,
    input  logic [IMM_W-1:0] signed_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  alu_res,
    output logic [XLEN-1:0]  branch_addr,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v
);
    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

    state_t            state_r, state_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   mcand_r, mplier_r, acc_r, bt_mul_r;
    logic              s_mul_r;

    logic              accept_s, mem_s, is_mul_s, mul_done_s, flag_ld_s;
    logic [3:0]        cmd_s;
    logic [XLEN-1:0]   op_b_s, res_s, sext_s, bt_s;
    logic [XLEN:0]     sum_s;
    logic              cin_s, ov_s;
    logic              n_s, z_s, c_s, v_s;

    // Handshake: accept only in IDLE when the output register is free or draining.
    always_comb begin
        in_ready   = (state_r == ST_IDLE) && (!out_valid || out_ready);
        accept_s   = in_valid && in_ready;
        mem_s      = mem_r_en || mem_w_en;
        is_mul_s   = mul && (MUL_EN != 0) && !mem_s;
        mul_done_s = (state_r == ST_MUL) && (cnt_r == CNT_W'(XLEN));
    end

    // Command decode: address calculations force ADD; MUL without a multiplier is MOV.
    always_comb begin
        if (mem_s) begin
            cmd_s = CMD_ADD;
        end else if (mul) begin
            cmd_s = CMD_MOV;
        end else begin
            cmd_s = exe_cmd;
        end
    end

    // Single-cycle ALU: one XLEN+1 adder serves ADD/ADC/SUB/SBC (subtract = add ~b).
    always_comb begin
        op_b_s    = ((cmd_s == CMD_SUB) || (cmd_s == CMD_SBC)) ? ~val2 : val2;
        case (cmd_s)
            CMD_ADC, CMD_SBC: cin_s = c;
            CMD_SUB:          cin_s = 1'b1;
            default:          cin_s = 1'b0;
        endcase
        sum_s     = {1'b0, val1} + {1'b0, op_b_s} + {{XLEN{1'b0}}, cin_s};
        ov_s      = (val1[XLEN-1] == op_b_s[XLEN-1]) && (sum_s[XLEN-1] != val1[XLEN-1]);
        res_s     = '0;
        c_s       = c;
        v_s       = v;
        flag_ld_s = s && !mem_s;
        case (cmd_s)
            CMD_MOV: res_s = val2;
            CMD_MVN: res_s = ~val2;
            CMD_AND: res_s = val1 & val2;
            CMD_ORR: res_s = val1 | val2;
            CMD_EOR: res_s = val1 ^ val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
                res_s = sum_s[XLEN-1:0];
                c_s   = sum_s[XLEN];
                v_s   = ov_s;
            end
            default: begin
                res_s     = '0;
                flag_ld_s = 1'b0;
            end
        endcase
        n_s = res_s[XLEN-1];
        z_s = (res_s == '0);
    end

    // Branch target: pc + sign-extended word offset, wrapping at XLEN bits.
    always_comb begin
        sext_s = {{(XLEN-IMM_W){signed_imm[IMM_W-1]}}, signed_imm};
        bt_s   = pc + (sext_s << 2);
    end

    // FSM next state: enter MUL on a multiply accept, leave once XLEN bits are done.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && is_mul_s) begin
                    state_nx_s = ST_MUL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Multiplier datapath: one multiplier bit per cycle into a low-half accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            bt_mul_r <= '0;
            s_mul_r  <= 1'b0;
        end else if (accept_s && is_mul_s) begin
            cnt_r    <= '0;
            mcand_r  <= val1;
            mplier_r <= val2;
            acc_r    <= '0;
            bt_mul_r <= bt_s;
            s_mul_r  <= s;
        end else if ((state_r == ST_MUL) && !mul_done_s) begin
            cnt_r    <= cnt_r + CNT_W'(1);
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            acc_r    <= acc_r + (mplier_r[0] ? mcand_r : '0);
        end
    end

    // Output register and flags: load on completion, clear valid on a plain drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            alu_res     <= '0;
            branch_addr <= '0;
            n           <= 1'b0;
            z           <= 1'b0;
            c           <= 1'b0;
            v           <= 1'b0;
        end else if (accept_s && !is_mul_s) begin
            out_valid   <= 1'b1;
            alu_res     <= res_s;
            branch_addr <= bt_s;
            if (flag_ld_s) begin
                n <= n_s;
                z <= z_s;
                c <= c_s;
                v <= v_s;
            end
        end else if (mul_done_s) begin
            out_valid   <= 1'b1;
            alu_res     <= acc_r;
            branch_addr <= bt_mul_r;
            if (s_mul_r) begin
                n <= acc_r[XLEN-1];
                z <= (acc_r == '0);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
